ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/ram_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the RAM-protocol arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Grant index width; a single-bit index is kept even for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last granted port.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(last) + k) % N);
      if (!found && req[pos]) begin
        found         = 1'b1;
        grant_idx     = pos;
        grant_oh[pos] = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Multiplexes NUM_PORTS upstream RAM-protocol masters onto one downstream port,
// one request at a time, with round-robin fairness and an optional busy timeout.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_PORTS-1:0]                       s_en,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]     s_we,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]       s_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]       s_din,
  output logic [NUM_PORTS-1:0]                       s_busy,
  output logic [NUM_PORTS-1:0]                       s_ack,
  output logic [DATA_WIDTH-1:0]                      s_dout,
  output logic [NUM_PORTS-1:0]                       s_err,
  output logic                                       m_en,
  output logic [DATA_WIDTH/8-1:0]                    m_we,
  output logic [ADDR_WIDTH-1:0]                      m_addr,
  output logic [DATA_WIDTH-1:0]                      m_din,
  input  logic                                       m_busy,
  input  logic [DATA_WIDTH-1:0]                      m_dout,
  input  logic                                       m_err,
  output logic [1:0]                                 dbg_state
);

  localparam int IW = idx_width(NUM_PORTS);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  // Handshake: a request completes in the cycle s_en=1 and s_busy=0 on both
  // sides; the response (s_ack/s_err/s_dout) follows exactly one cycle later.

  state_t               state, state_d;
  logic [IW-1:0]        grant, grant_d;
  logic [NUM_PORTS-1:0] grant_oh, grant_oh_d;
  logic [IW-1:0]        last, last_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic                 timed_out, timed_out_d;
  logic                 timeout_hit;

  logic [NUM_PORTS-1:0] arb_oh;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr (
    .req       (s_en),
    .last      (last),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES));
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      grant_oh  <= '0;
      last      <= IW'(NUM_PORTS - 1);
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      grant_oh  <= grant_oh_d;
      last      <= last_d;
      cnt       <= cnt_d;
      timed_out <= timed_out_d;
    end
  end

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    grant_oh_d  = grant_oh;
    last_d      = last;
    cnt_d       = cnt;
    timed_out_d = timed_out;
    m_en        = 1'b0;
    m_we        = '0;
    m_addr      = s_addr[grant];
    m_din       = s_din[grant];
    s_busy      = '1;
    s_ack       = '0;
    s_err       = '0;
    s_dout      = '0;

    case (state)
      ST_REQ: begin
        m_we = s_we[grant];
        m_en = !timeout_hit;
        if (timeout_hit || !m_busy) begin
          s_busy      = ~grant_oh;
          state_d     = ST_RESP;
          timed_out_d = timeout_hit;
        end else if (cnt != '1) begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_RESP: begin
        // A timed-out transfer reports an error with zero data, whatever downstream says.
        s_ack  = grant_oh;
        s_err  = (timed_out || m_err) ? grant_oh : '0;
        s_dout = timed_out ? '0 : m_dout;
      end
      default: ;
    endcase

    if (state != ST_REQ) begin
      if (arb_any) begin
        state_d     = ST_REQ;
        grant_d     = arb_idx;
        grant_oh_d  = arb_oh;
        last_d      = arb_idx;
        cnt_d       = '0;
        timed_out_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

endmodule
